// File: rtl/seq_engine.sv
// Paced sequence generator: Fibonacci, up-count or down-count, chosen per run.
// Each emitted value carries a one-cycle valid pulse and registered even parity.
module seq_engine #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PROG_W   = 3,
    parameter int unsigned BASE_DIV = 4,
    parameter int unsigned LIMIT    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stop,
    input  logic              update,
    input  logic [PROG_W-1:0] prog,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MAX_T = BASE_DIV << ((2 ** PROG_W) - 1);
    // Wide enough to hold the longest period itself, not just its last count.
    localparam int unsigned PS_W  = $clog2(MAX_T + 1);
    localparam int unsigned FIB_W = DATA_W + 1;

    localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(LIMIT);

    localparam logic [1:0] ModeFib  = 2'd0;
    localparam logic [1:0] ModeUp   = 2'd1;
    localparam logic [1:0] ModeDown = 2'd2;
    localparam logic [1:0] ModeRsvd = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [PROG_W-1:0]  prog_q, prog_d;
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               parity_q, parity_d;
    logic               valid_q, valid_d;
    logic [FIB_W-1:0]   prev_q, prev_d;
    logic [FIB_W-1:0]   cur_q, cur_d;

    logic [PS_W-1:0]    period;
    logic               tick;
    logic [FIB_W-1:0]   fib_sum;
    logic               step_ok;
    logic [DATA_W-1:0]  step_val;

    assign period = PS_W'(BASE_DIV) << prog_q;
    assign tick   = (state_q == StRun) && (presc_q == period - PS_W'(1));

    // Candidate next value for the active mode; step_ok low means the run ends.
    always_comb begin
        fib_sum  = prev_q + cur_q;
        step_ok  = 1'b0;
        step_val = data_q;
        unique case (mode_q)
            ModeFib: begin
                step_ok  = ~fib_sum[DATA_W];
                step_val = fib_sum[DATA_W-1:0];
            end
            ModeUp: begin
                step_ok  = data_q < LIMIT_V;
                step_val = data_q + DATA_W'(1);
            end
            ModeDown: begin
                step_ok  = data_q != '0;
                step_val = data_q - DATA_W'(1);
            end
            default: begin
                step_ok  = 1'b0;
                step_val = data_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            mode_q   <= ModeFib;
            prog_q   <= '0;
            presc_q  <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
            prev_q   <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            prog_q   <= prog_d;
            presc_q  <= presc_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        prog_d   = prog_q;
        data_d   = data_q;
        parity_d = parity_q;
        valid_d  = 1'b0;
        prev_d   = prev_q;
        cur_d    = cur_q;
        if (state_q == StRun && !tick) begin
            presc_d = presc_q + PS_W'(1);
        end else begin
            presc_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !stop && mode != ModeRsvd) begin
                    state_d  = StRun;
                    mode_d   = mode;
                    valid_d  = 1'b1;
                    data_d   = (mode == ModeDown) ? LIMIT_V : '0;
                    parity_d = (mode == ModeDown) ? ^LIMIT_V : 1'b0;
                    // Seeding prev=1 makes the first Fibonacci step after 0 yield 1.
                    prev_d   = FIB_W'(1);
                    cur_d    = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (step_ok) begin
                        data_d   = step_val;
                        parity_d = ^step_val;
                        valid_d  = 1'b1;
                        if (mode_q == ModeFib) begin
                            prev_d = cur_q;
                            cur_d  = fib_sum;
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (update) begin
            prog_d  = prog;
            presc_d = '0;
        end
    end

    always_comb begin
        data_out   = data_q;
        parity     = parity_q;
        data_valid = valid_q;
        busy       = state_q != StIdle;
        done       = state_q == StDone;
    end

endmodule
